// File: rtl/chien_pkg.sv
// Shared GF(2^M) helpers, width helpers and FSM state type for the parallel Chien search.
package chien_pkg;

  localparam int          GF_M    = 13;
  localparam logic [31:0] GF_PRIM = 32'h201B;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Shift-and-add multiply, reducing by prim as each bit of b is consumed (msb first).
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                         input int m, input logic [31:0] prim);
    logic [31:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < m) begin
        r = r << 1;
        if ((r & (32'd1 << m)) != 32'd0) r = r ^ prim;
        if (((b >> i) & 32'd1) != 32'd0) r = r ^ a;
      end
    end
    return r & ((32'd1 << m) - 32'd1);
  endfunction

  function automatic logic [31:0] gf_pow(input int e, input int m, input logic [31:0] prim);
    int          ee;
    logic [31:0] res;
    logic [31:0] base;
    ee   = e % ((1 << m) - 1);
    res  = 32'd1;
    base = 32'd2;
    for (int i = 0; i < 31; i++) begin
      if (((ee >> i) & 1) != 0) res = gf_mul(res, base, m, prim);
      base = gf_mul(base, base, m, prim);
    end
    return res;
  endfunction

endpackage

// File: rtl/gf_cmul.sv
// Combinational multiply of a GF(2^M) symbol by the constant alpha^K.
module gf_cmul
  import chien_pkg::*;
#(
  parameter int         M    = 13,
  parameter logic [M:0] PRIM = 14'h201B,
  parameter int         K    = 0
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  localparam logic [31:0] PRIM32 = 32'(PRIM);
  localparam logic [31:0] C      = gf_pow(K, M, PRIM32);

  logic [31:0] prod;

  always_comb begin
    prod = gf_mul(32'(a), C, M, PRIM32);
    y    = prod[M-1:0];
  end

endmodule

// File: rtl/chien_search_par.sv
// P-lane Chien search: evaluates the error locator at P consecutive powers of alpha per beat
// and streams root flags with ready/valid handshake, then reports root count and failure.
module chien_search_par
  import chien_pkg::*;
#(
  parameter int          M     = 13,
  parameter int          T     = 8,
  parameter int          P     = 16,
  parameter int          NPOS  = 8191,
  parameter int          START = 0,
  parameter logic [M:0]  PRIM  = 14'h201B,
  localparam int         DW    = clog2(T + 1),
  localparam int         BW    = clog2(NPOS + P),
  localparam int         CW    = clog2(NPOS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [(T+1)*M-1:0]   lambda,
  input  logic [DW-1:0]        deg,
  output logic                 ready,
  output logic                 err_valid,
  input  logic                 out_ready,
  output logic [P-1:0]         err_flags,
  output logic [BW-1:0]        err_base,
  output logic                 done,
  output logic [CW-1:0]        root_count,
  output logic                 fail
);

  localparam int              NBEATS    = (NPOS + P - 1) / P;
  localparam int              KW        = clog2(NBEATS + 1);
  localparam logic [BW-1:0]   LAST_BASE = BW'((NBEATS - 1) * P);
  localparam logic [KW-1:0]   BEAT_END  = KW'(NBEATS);

  state_e            state_q, state_d;
  logic [M-1:0]      coef_q [0:T];
  logic [M-1:0]      coef_d [0:T];
  logic [M-1:0]      reg_q  [1:T];
  logic [M-1:0]      reg_d  [1:T];
  logic [DW-1:0]     deg_q, deg_d;
  logic [KW-1:0]     beat_q, beat_d;
  logic              err_valid_q, err_valid_d;
  logic [P-1:0]      err_flags_q, err_flags_d;
  logic [BW-1:0]     err_base_q, err_base_d;
  logic [CW-1:0]     root_count_q, root_count_d;
  logic              fail_q, fail_d;

  logic [M-1:0]      load_prod [1:T];
  logic [M-1:0]      step_prod [1:T];
  logic [M-1:0]      lane_term [0:P-1][1:T];
  logic [M-1:0]      sum_v;
  logic [P-1:0]      lane_hit;
  logic [BW-1:0]     issue_base;
  logic [CW-1:0]     beat_pop;
  logic              issue;
  logic              accept;

  genvar gi, gj;
  generate
    for (gi = 1; gi <= T; gi++) begin : g_coef
      gf_cmul #(.M(M), .PRIM(PRIM), .K(gi * START)) u_load (
        .a (coef_q[gi]),
        .y (load_prod[gi])
      );
      gf_cmul #(.M(M), .PRIM(PRIM), .K(gi * P)) u_step (
        .a (reg_q[gi]),
        .y (step_prod[gi])
      );
      for (gj = 0; gj < P; gj++) begin : g_lane
        gf_cmul #(.M(M), .PRIM(PRIM), .K(gi * gj)) u_lane (
          .a (reg_q[gi]),
          .y (lane_term[gj][gi])
        );
      end
    end
  endgenerate

  // Lane j sees Lambda(alpha^(START + beat*P + j)); lanes past NPOS are masked off.
  always_comb begin
    issue_base = BW'(beat_q) * BW'(P);
    lane_hit   = '0;
    sum_v      = '0;
    for (int j = 0; j < P; j++) begin
      sum_v = coef_q[0];
      for (int l = 1; l <= T; l++) begin
        sum_v = sum_v ^ lane_term[j][l];
      end
      lane_hit[j] = (sum_v == '0) && ((32'(issue_base) + 32'(j)) < 32'(NPOS));
    end
  end

  always_comb begin
    beat_pop = '0;
    for (int j = 0; j < P; j++) begin
      beat_pop = beat_pop + CW'(err_flags_q[j]);
    end
  end

  assign accept = err_valid_q && out_ready;
  assign issue  = (state_q == RUN) && (beat_q != BEAT_END) && (!err_valid_q || out_ready);

  always_comb begin
    state_d      = state_q;
    coef_d       = coef_q;
    reg_d        = reg_q;
    deg_d        = deg_q;
    beat_d       = beat_q;
    err_valid_d  = err_valid_q;
    err_flags_d  = err_flags_q;
    err_base_d   = err_base_q;
    root_count_d = root_count_q;
    fail_d       = fail_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int l = 0; l <= T; l++) begin
            coef_d[l] = lambda[l*M +: M];
          end
          deg_d   = deg;
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int l = 1; l <= T; l++) begin
          reg_d[l] = load_prod[l];
        end
        root_count_d = '0;
        fail_d       = 1'b0;
        beat_d       = '0;
        state_d      = RUN;
      end
      RUN: begin
        if (accept) begin
          root_count_d = root_count_q + beat_pop;
          err_valid_d  = 1'b0;
          if (err_base_q == LAST_BASE) begin
            fail_d  = (root_count_d != CW'(deg_q)) || (coef_q[0] == '0);
            state_d = DONE;
          end
        end
        // A new beat replaces a drained one in the same cycle it is accepted.
        if (issue) begin
          err_valid_d = 1'b1;
          err_flags_d = lane_hit;
          err_base_d  = issue_base;
          beat_d      = beat_q + KW'(1);
          for (int l = 1; l <= T; l++) begin
            reg_d[l] = step_prod[l];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      for (int l = 0; l <= T; l++) coef_q[l] <= '0;
      for (int l = 1; l <= T; l++) reg_q[l] <= '0;
      deg_q        <= '0;
      beat_q       <= '0;
      err_valid_q  <= 1'b0;
      err_flags_q  <= '0;
      err_base_q   <= '0;
      root_count_q <= '0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      coef_q       <= coef_d;
      reg_q        <= reg_d;
      deg_q        <= deg_d;
      beat_q       <= beat_d;
      err_valid_q  <= err_valid_d;
      err_flags_q  <= err_flags_d;
      err_base_q   <= err_base_d;
      root_count_q <= root_count_d;
      fail_q       <= fail_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign err_valid  = err_valid_q;
  assign err_flags  = err_flags_q;
  assign err_base   = err_base_q;
  assign root_count = root_count_q;
  assign fail       = fail_q;

endmodule
